// File: rtl/pkt_tx_scheduler.sv
// pkt_tx_scheduler
//
// Picks one pending packet (handshake or data), serializes it LSB first
// towards the bit stuffer, waits for the DPDM encoder to report end of
// packet, reports completion to the requester, and then enforces a
// fixed idle gap before the next grant.
//
// Parameters:
//   GAP_CYCLES   idle cycles forced after each out_done (1..15)
//
// Ports:
//   clock        system clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   hs_req       handshake request level, held until hs_done
//   hs_pid       handshake PID nibble
//   data_req     data request level, held until data_done
//   data_pid     data PID nibble
//   data_payload 8-byte payload, byte 0 in bits [7:0]
//   data_crc16   precomputed CRC16, sent after the payload
//   bs_stall     bit stuffer inserting a stuff bit, out_bit not consumed
//   out_done     one-cycle pulse from the encoder after EOP
//   out_bit      serial bit to the bit stuffer
//   out_sending  out_bit is valid
//   hs_done      one-cycle pulse, handshake packet finished
//   data_done    one-cycle pulse, data packet finished
//   busy         high whenever the scheduler is not idle
module pkt_tx_scheduler #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hs_req,
  input  logic [3:0]  hs_pid,
  input  logic        data_req,
  input  logic [3:0]  data_pid,
  input  logic [63:0] data_payload,
  input  logic [15:0] data_crc16,
  input  logic        bs_stall,
  input  logic        out_done,
  output logic        out_bit,
  output logic        out_sending,
  output logic        hs_done,
  output logic        data_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } state_e;

  localparam logic [6:0] HS_LAST   = 7'd7;
  localparam logic [6:0] DATA_LAST = 7'd87;
  localparam logic [6:0] GAP_LOAD  = 7'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [87:0] shift_q, shift_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        isHs_q, isHs_d;
  logic        hsDone_q, hsDone_d;
  logic        dataDone_q, dataDone_d;

  // The shift register shifts in zeros, so out_bit naturally returns to 0
  // once the last packet bit has been consumed.
  assign out_bit     = shift_q[0];
  assign out_sending = (state_q == SEND);
  assign hs_done     = hsDone_q;
  assign data_done   = dataDone_q;
  assign busy        = (state_q != IDLE);

  // State register; reset aborts any packet in flight without a done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      isHs_q     <= 1'b0;
      hsDone_q   <= 1'b0;
      dataDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      isHs_q     <= isHs_d;
      hsDone_q   <= hsDone_d;
      dataDone_q <= dataDone_d;
    end
  end

  // Next-state logic. The counter is shared: bits remaining during SEND,
  // gap cycles remaining during GAP.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    isHs_d     = isHs_q;
    hsDone_d   = 1'b0;
    dataDone_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Handshakes win: they are short and latency-critical.
        if (hs_req) begin
          shift_d = {80'b0, ~hs_pid, hs_pid};
          cnt_d   = HS_LAST;
          isHs_d  = 1'b1;
          state_d = SEND;
        end else if (data_req) begin
          shift_d = {data_crc16, data_payload, ~data_pid, data_pid};
          cnt_d   = DATA_LAST;
          isHs_d  = 1'b0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (!bs_stall) begin
          shift_d = {1'b0, shift_q[87:1]};
          if (cnt_q == 7'd0) begin
            state_d = WAIT_DONE;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
      end

      WAIT_DONE: begin
        if (out_done) begin
          hsDone_d   = isHs_q;
          dataDone_d = ~isHs_q;
          cnt_d      = GAP_LOAD;
          state_d    = GAP;
        end
      end

      GAP: begin
        if (cnt_q == 7'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// tb_pkt_tx_scheduler
//
// Directed, self-checking bench for pkt_tx_scheduler. Inputs are driven
// and outputs sampled on the falling clock edge, away from the active edge.
module tb_pkt_tx_scheduler;

  localparam int GAP = 2;

  logic        clock;
  logic        reset_n;
  logic        hs_req;
  logic [3:0]  hs_pid;
  logic        data_req;
  logic [3:0]  data_pid;
  logic [63:0] data_payload;
  logic [15:0] data_crc16;
  logic        bs_stall;
  logic        out_done;
  logic        out_bit;
  logic        out_sending;
  logic        hs_done;
  logic        data_done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Hand-built expected wire images: {crc, payload, ~pid, pid}.
  logic [87:0] expData = 88'h544a_40aa11b7682df6d8_C3;
  logic [7:0]  expAck  = 8'hD2;

  pkt_tx_scheduler #(.GAP_CYCLES(GAP)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .hs_req       (hs_req),
    .hs_pid       (hs_pid),
    .data_req     (data_req),
    .data_pid     (data_pid),
    .data_payload (data_payload),
    .data_crc16   (data_crc16),
    .bs_stall     (bs_stall),
    .out_done     (out_done),
    .out_bit      (out_bit),
    .out_sending  (out_sending),
    .hs_done      (hs_done),
    .data_done    (data_done),
    .busy         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Loads the data requester inputs with the reference packet.
  task automatic applyStimulus();
    data_pid     = 4'b0011;
    data_payload = 64'h40aa11b7682df6d8;
    data_crc16   = 16'h544a;
  endtask

  // Waits (bounded) for out_sending, then records one bit per consumed
  // cycle. At bit index stallAt, bs_stall is raised for one cycle.
  task automatic capturePacket(input int stallAt, output logic [87:0] bits,
                               output int nBits, output int sendCycles,
                               output bit timedOut);
    int waitCnt;
    int idx;
    bit stalledOnce;
    bits        = '0;
    nBits       = 0;
    sendCycles  = 0;
    timedOut    = 1'b0;
    idx         = 0;
    stalledOnce = 1'b0;
    waitCnt     = 0;
    while (!out_sending && waitCnt < 50) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!out_sending) begin
      timedOut = 1'b1;
      return;
    end
    while (out_sending && sendCycles < 200) begin
      sendCycles++;
      if (idx < 88) bits[idx] = out_bit;
      if (idx == stallAt && !stalledOnce) begin
        bs_stall    = 1'b1;
        stalledOnce = 1'b1;
      end else begin
        bs_stall = 1'b0;
        idx++;
      end
      @(negedge clock);
    end
    bs_stall = 1'b0;
    nBits    = idx;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    hs_req   = 1'b0;
    hs_pid   = 4'b0010;
    data_req = 1'b1;
    applyStimulus();
    bs_stall = 1'b0;
    out_done = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({out_bit, out_sending, hs_done, data_done, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b want=00000",
               {out_bit, out_sending, hs_done, data_done, busy});
    end
    data_req = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle busy got=%b want=0", busy);
    end
  endtask

  // Pulses out_done from WAIT_DONE, checks the done pulse and the gap.
  task automatic finishPacket(input bit expHs, input string name);
    out_done = 1'b1;
    @(negedge clock);
    out_done = 1'b0;
    checks++;
    if ({hs_done, data_done} !== {expHs, ~expHs}) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse got hs/data=%b want=%b", name,
               {hs_done, data_done}, {expHs, ~expHs});
    end
    @(negedge clock);
    checks++;
    if ({hs_done, data_done, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL %s_pulse_end got hs/data/busy=%b want=001", name,
               {hs_done, data_done, busy});
    end
    repeat (GAP - 1) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_gap_to_idle busy got=%b want=0", name, busy);
    end
  endtask

  task automatic test_data_packet();
    logic [87:0] bits;
    int n, cyc;
    bit to;
    applyStimulus();
    data_req = 1'b1;
    capturePacket(-1, bits, n, cyc, to);
    data_req = 1'b0;
    checks++;
    if (to || bits !== expData || n != 88) begin
      errors++;
      $display("[TB] FAIL data_bits got=%h n=%0d to=%0d want=%h n=88", bits, n, to, expData);
    end
    checks++;
    if (cyc != 88) begin
      errors++;
      $display("[TB] FAIL data_sending_len got=%0d want=88", cyc);
    end
    checks++;
    if ({busy, data_done, out_bit} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL data_wait_done busy/done/bit got=%b want=100",
               {busy, data_done, out_bit});
    end
    finishPacket(1'b0, "data");
  endtask

  task automatic test_handshake();
    logic [87:0] bits;
    int n, cyc;
    bit to;
    hs_pid = 4'b0010;
    hs_req = 1'b1;
    capturePacket(-1, bits, n, cyc, to);
    hs_req = 1'b0;
    checks++;
    if (to || bits[7:0] !== expAck || n != 8 || cyc != 8) begin
      errors++;
      $display("[TB] FAIL hs_bits got=%h n=%0d cyc=%0d want=%h n=8 cyc=8",
               bits[7:0], n, cyc, expAck);
    end
    finishPacket(1'b1, "hs");
  endtask

  task automatic test_back_to_back();
    logic [87:0] bits;
    int n, cyc, idle;
    bit to;
    applyStimulus();
    hs_pid   = 4'b0010;
    hs_req   = 1'b1;
    data_req = 1'b1;
    capturePacket(-1, bits, n, cyc, to);
    hs_req = 1'b0;
    checks++;
    if (to || bits[7:0] !== expAck || cyc != 8) begin
      errors++;
      $display("[TB] FAIL prio_first_is_hs got=%h cyc=%0d want=%h cyc=8",
               bits[7:0], cyc, expAck);
    end
    out_done = 1'b1;
    @(negedge clock);
    out_done = 1'b0;
    checks++;
    if ({hs_done, data_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL prio_hs_done got hs/data=%b want=10", {hs_done, data_done});
    end
    idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_sending) break;
      idle++;
    end
    checks++;
    if (idle != GAP) begin
      errors++;
      $display("[TB] FAIL prio_gap_cycles got=%0d want=%0d", idle, GAP);
    end
    capturePacket(-1, bits, n, cyc, to);
    data_req = 1'b0;
    checks++;
    if (to || bits !== expData || cyc != 88) begin
      errors++;
      $display("[TB] FAIL prio_second_is_data got=%h cyc=%0d want=%h cyc=88",
               bits, cyc, expData);
    end
    finishPacket(1'b0, "prio_data");
  endtask

  task automatic test_stall();
    logic [87:0] bits;
    int n, cyc;
    bit to;
    applyStimulus();
    data_req = 1'b1;
    capturePacket(5, bits, n, cyc, to);
    data_req = 1'b0;
    checks++;
    if (to || bits !== expData || n != 88) begin
      errors++;
      $display("[TB] FAIL stall_bits got=%h n=%0d want=%h", bits, n, expData);
    end
    checks++;
    if (cyc != 89) begin
      errors++;
      $display("[TB] FAIL stall_sending_len got=%0d want=89", cyc);
    end
    finishPacket(1'b0, "stall");
  endtask

  task automatic test_reset_mid_packet();
    logic [87:0] bits;
    int n, cyc, waitCnt;
    bit to;
    applyStimulus();
    data_req = 1'b1;
    waitCnt  = 0;
    while (!out_sending && waitCnt < 50) begin
      @(negedge clock);
      waitCnt++;
    end
    repeat (40) @(negedge clock);
    checks++;
    if (out_sending !== 1'b1 || out_bit !== expData[40]) begin
      errors++;
      $display("[TB] FAIL abort_at_bit40 got sending=%b bit=%b want=1 %b",
               out_sending, out_bit, expData[40]);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_sending, busy, out_bit, data_done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL abort_async got sending/busy/bit/done=%b want=0000",
               {out_sending, busy, out_bit, data_done});
    end
    @(negedge clock);
    reset_n = 1'b1;
    capturePacket(-1, bits, n, cyc, to);
    data_req = 1'b0;
    checks++;
    if (to || bits !== expData || cyc != 88) begin
      errors++;
      $display("[TB] FAIL abort_restart got=%h cyc=%0d want=%h cyc=88",
               bits, cyc, expData);
    end
    finishPacket(1'b0, "restart");
  endtask

  task automatic test_stray_done();
    logic [87:0] bits;
    int n, cyc;
    bit to;
    out_done = 1'b1;
    @(negedge clock);
    out_done = 1'b0;
    checks++;
    if ({busy, hs_done, data_done, out_sending} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL stray_idle got busy/hs/data/send=%b want=0000",
               {busy, hs_done, data_done, out_sending});
    end
    hs_pid = 4'b1110;
    hs_req = 1'b1;
    capturePacket(-1, bits, n, cyc, to);
    hs_req = 1'b0;
    checks++;
    if (to || bits[7:0] !== 8'h1E || cyc != 8) begin
      errors++;
      $display("[TB] FAIL stall_pid_bits got=%h cyc=%0d want=1e cyc=8", bits[7:0], cyc);
    end
    out_done = 1'b1;
    @(negedge clock);
    checks++;
    if (hs_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stray_gap_first got hs_done=%b want=1", hs_done);
    end
    // out_done stays high into GAP: must be ignored there.
    @(negedge clock);
    out_done = 1'b0;
    checks++;
    if ({hs_done, data_done, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL stray_gap got hs/data/busy=%b want=001",
               {hs_done, data_done, busy});
    end
    repeat (GAP - 1) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_gap_idle busy got=%b want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_data_packet();
    test_handshake();
    test_back_to_back();
    test_stall();
    test_reset_mid_packet();
    test_stray_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_tx_scheduler.md
PKT_TX_SCHEDULER -- requirements
Module: pkt_tx_scheduler

Interface
REQ-001 Parameter: GAP_CYCLES, 2, idle cycles forced after each packet's out_done before the next grant (range 1..15).
REQ-002 Port: clock  input  1  single system clock; all state on posedge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: hs_req  input  1  handshake requester; level, held until hs_done.
REQ-005 Port: hs_pid  input  4  handshake PID (ACK=4'b0010, NAK=4'b1010, STALL=4'b1110).
REQ-006 Port: data_req  input  1  data requester; level, held until data_done.
REQ-007 Port: data_pid  input  4  data PID (DATA0=4'b0011, DATA1=4'b1011).
REQ-008 Port: data_payload  input  64  8-byte payload; byte 0 = bits [7:0].
REQ-009 Port: data_crc16  input  16  precomputed CRC16; sent after payload.
REQ-010 Port: bs_stall  input  1  bit stuffer inserting a stuff bit; current out_bit not consumed this cycle.
REQ-011 Port: out_done  input  1  one-cycle pulse from DPDM encoder after EOP driven.
REQ-012 Port: out_bit  output  1  serial bit to bit stuffer (in_bit).
REQ-013 Port: out_sending  output  1  bit stream valid to bit stuffer (bs_sending).
REQ-014 Port: hs_done  output  1  one-cycle pulse, handshake packet fully on the wire.
REQ-015 Port: data_done  output  1  one-cycle pulse, data packet fully on the wire.
REQ-016 Port: busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, SEND, WAIT_DONE, GAP.
REQ-018 PID byte SHALL be {~pid, pid}; every field SHALL be serialized LSB first.
REQ-019 Data packet SHALL be 88 bits {data_crc16, data_payload, PID byte}, bit 0 first; handshake packet SHALL be 8 bits (PID byte only); SYNC and EOP are produced downstream.
REQ-020 IDLE: at a posedge with hs_req=1 SHALL grant handshake; else with data_req=1 SHALL grant data; handshake has fixed priority.
REQ-021 At the grant edge the packet SHALL be latched into an 88-bit shift register, the bit counter loaded with length-1, state -> SEND, out_sending=1, out_bit=bit 0.
REQ-022 SEND: each posedge with bs_stall=0 SHALL consume the current bit; with bs_stall=1 out_bit and counter SHALL hold.
REQ-023 The edge consuming the last bit SHALL set out_sending=0, state -> WAIT_DONE; out_sending SHALL be high exactly length + (stalled cycles) cycles.
REQ-024 WAIT_DONE: posedge with out_done=1 SHALL pulse the granted requester's done for one cycle and enter GAP with counter = GAP_CYCLES-1.
REQ-025 GAP: SHALL decrement each cycle and return to IDLE after GAP_CYCLES cycles; requests SHALL not be granted during GAP.
REQ-026 Requester inputs SHALL be sampled only at the grant edge; changes or drops during SEND/WAIT_DONE SHALL not affect the packet in flight.
REQ-027 out_done outside WAIT_DONE and bs_stall outside SEND SHALL be ignored.
REQ-028 A requester still asserting after its done pulse SHALL be treated as a new request in the next IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, out_bit=0, out_sending=0, hs_done=0, data_done=0, busy=0, counters and shift register cleared, including mid-packet; no done pulse SHALL be issued for an aborted packet.

Verification
REQ-030 data_req, data_pid=4'b0011, payload=64'h40aa11b7682df6d8, crc=16'h544a -> 88 consecutive out_bit values = 88'h544a_40aa11b7682df6d8_C3 LSB first, out_sending high 88 cycles; out_done pulse -> data_done one cycle later.
REQ-031 hs_req with hs_pid=4'b0010 -> out_bits of 8'hD2 LSB first (0,1,0,0,1,0,1,1), out_sending high 8 cycles, hs_done after out_done.
REQ-032 hs_req and data_req rise same cycle -> handshake sent first, then GAP_CYCLES idle cycles after hs_done, then data packet.
REQ-033 bs_stall=1 for 1 cycle at bit 5 of a data packet -> bit 5 held 2 cycles, out_sending high 89 cycles, bit sequence unchanged.
REQ-034 reset_n pulsed low at bit 40 of a data packet -> out_sending=0 immediately, no data_done; held data_req restarts packet from bit 0.
REQ-035 Stray out_done in IDLE and GAP -> no done pulse, no state change.
